// File: rtl/mem_access_unit.sv
// mem_access_unit: accepts one load/store request at a time and runs it against a
// single-port memory with an ack-based wait-state handshake. Halfword stores are a
// read-modify-write pair, halfword loads are sign-extended, and every request ends
// with a one-cycle response pulse for the control FSM.
//
// Each memory phase is followed by exactly one cycle with mem_en low (the "done"
// cycle). This cycle gives the one-cycle gap between the RMW read and write phases.
// It also sets the fixed accept-to-response latency.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15,  // max un-acked mem_en cycles, 1..255
    parameter int unsigned AW      = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_half,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [2:0]    stateQ, stateD;
    logic          doneQ;      // memory phase finished, mem_en is in its low cycle
    logic [7:0]    cntQ;
    logic          addr1Q;     // selects the upper halfword
    logic          halfQ;
    logic [15:0]   wdataQ;     // halfword store data for the RMW merge
    logic          errQ;
    logic [31:0]   stageQ;     // result presented on resp_rdata at the next response
    logic [31:0]   rdataQ;
    logic          memEnQ;
    logic          memWeQ;
    logic [AW-1:0] memAddrQ;
    logic [31:0]   memWdataQ;

    logic          accept;
    logic          misaligned;
    logic          inMem;
    logic          ackEvt;
    logic          toEvt;
    logic          finish;
    logic          startWrPhase;
    logic [AW-1:0] reqWordAddr;
    logic [15:0]   loadHalf;
    logic [31:0]   loadValue;
    logic [31:0]   mergedWord;

    // Request decode, handshake events and data-path selects.
    always_comb begin
        accept       = (stateQ == IDLE) && req_valid;
        misaligned   = req_half ? req_addr[0] : (req_addr[1:0] != 2'b00);
        reqWordAddr  = AW'(req_addr[31:2]);
        inMem        = (stateQ == RD) || (stateQ == WR) ||
                       (stateQ == RMW_RD) || (stateQ == RMW_WR);
        // memEnQ is only ever high in a memory state, so ack is ignored elsewhere.
        ackEvt       = memEnQ && mem_ack;
        toEvt        = memEnQ && !mem_ack && (cntQ == TimeoutLast);
        finish       = inMem && doneQ;
        startWrPhase = finish && (stateQ == RMW_RD) && !errQ;
        loadHalf     = addr1Q ? mem_rdata[31:16] : mem_rdata[15:0];
        loadValue    = halfQ ? {{16{loadHalf[15]}}, loadHalf} : mem_rdata;
        mergedWord   = addr1Q ? {wdataQ, mem_rdata[15:0]} : {mem_rdata[31:16], wdataQ};
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        stateD = RESP;
                    end else if (!req_write) begin
                        stateD = RD;
                    end else if (!req_half) begin
                        stateD = WR;
                    end else begin
                        stateD = RMW_RD;
                    end
                end
            end
            RD, WR, RMW_RD, RMW_WR: begin
                if (doneQ) begin
                    stateD = startWrPhase ? RMW_WR : RESP;
                end
            end
            RESP:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Marks the single mem_en-low cycle that follows an ack or a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doneQ <= 1'b0;
        end else if (ackEvt || toEvt) begin
            doneQ <= 1'b1;
        end else if (finish) begin
            doneQ <= 1'b0;
        end
    end

    // Wait-state counter: cleared at the start of each phase, counts un-acked cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else if (accept || startWrPhase) begin
            cntQ <= '0;
        end else if (memEnQ && !mem_ack) begin
            cntQ <= cntQ + 8'd1;
        end
    end

    // Request fields needed after accept; the requester is free to change its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr1Q <= 1'b0;
            halfQ  <= 1'b0;
            wdataQ <= '0;
        end else if (accept) begin
            addr1Q <= req_addr[1];
            halfQ  <= req_half;
            wdataQ <= req_wdata[15:0];
        end
    end

    // Registered memory interface; held stable until ack or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memEnQ    <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            if (accept && !misaligned) begin
                memEnQ   <= 1'b1;
                memWeQ   <= req_write && !req_half;
                memAddrQ <= reqWordAddr;
                if (req_write && !req_half) begin
                    memWdataQ <= req_wdata;
                end
            end else if (startWrPhase) begin
                memEnQ <= 1'b1;
                memWeQ <= 1'b1;
            end else if (ackEvt || toEvt) begin
                memEnQ <= 1'b0;
                memWeQ <= 1'b0;
            end
            if (ackEvt && (stateQ == RMW_RD)) begin
                memWdataQ <= mergedWord;
            end
        end
    end

    // Response error flag and load data; resp_rdata only changes when a response starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errQ   <= 1'b0;
            stageQ <= '0;
            rdataQ <= '0;
        end else begin
            if (accept) begin
                errQ   <= misaligned;
                stageQ <= rdataQ;
                if (misaligned) begin
                    rdataQ <= '0;
                end
            end else begin
                if (toEvt) begin
                    errQ <= 1'b1;
                end
                if (stateQ == RD) begin
                    if (ackEvt) begin
                        stageQ <= loadValue;
                    end else if (toEvt) begin
                        stageQ <= '0;
                    end
                end
                if (finish && !startWrPhase) begin
                    rdataQ <= stageQ;
                end
            end
        end
    end

    assign req_ready  = (stateQ == IDLE);
    assign resp_valid = (stateQ == RESP);
    assign resp_err   = (stateQ == RESP) && errQ;
    assign resp_rdata = rdataQ;
    assign mem_en     = memEnQ;
    assign mem_we     = memWeQ;
    assign mem_addr   = memAddrQ;
    assign mem_wdata  = memWdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit with a transaction-level model.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;
    localparam int MemWords = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write, req_half;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_access_unit #(.TIMEOUT(TO), .AW(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_half(req_half), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          delay;   // wait cycles before ack; >= TO means never ack
    } op_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cycle;
    } resp_t;

    op_t         opQ[$];
    resp_t       respQ[$];
    logic [31:0] refMem[MemWords];
    logic [31:0] simMem[MemWords];
    logic [31:0] lastRdata = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic boundFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no progress expected completion", name);
    endtask

    function automatic logic [31:0] loadModel(input logic [31:0] word, input logic half,
                                              input logic [31:0] addr);
        logic [31:0] h;
        if (!half) return word;
        h = ((addr / 2) % 2 == 1) ? (word >> 16) : (word % 32'h1_0000);
        return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
    endfunction

    function automatic logic [31:0] mergeModel(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [31:0] addr);
        logic [31:0] lo;
        lo = wdata % 32'h1_0000;
        if ((addr / 2) % 2 == 1) return (lo << 16) + (word % 32'h1_0000);
        return (word - (word % 32'h1_0000)) + lo;
    endfunction

    // Cycles one memory phase occupies: mem_en cycles plus the low cycle after it.
    function automatic int phaseLen(input int d);
        return ((d >= int'(TO)) ? int'(TO) : d + 1) + 1;
    endfunction

    task automatic setMem(input int idx, input logic [31:0] v);
        refMem[idx] = v;
        simMem[idx] = v;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((respQ.size() != 0 || opQ.size() != 0 || !req_ready) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) boundFail("drain");
    endtask

    // Model the request, queue its expected memory phases and response, then issue it.
    task automatic doReq(input logic wr, input logic half, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d1, input int d2,
                         input bit expectResp);
        int guard = 0;
        bit mis;
        int idx;
        int lat;
        logic [29:0] wa;
        logic [31:0] merged;
        resp_t r;
        while (!req_ready && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) boundFail("req_ready_wait");
        mis = half ? (addr % 2 != 0) : (addr % 4 != 0);
        wa  = 30'(addr / 4);
        idx = int'((addr / 4) % MemWords);
        r.err = 1'b0;
        r.rdata = lastRdata;
        lat = 1;
        if (mis) begin
            r.err = 1'b1;
            r.rdata = 32'd0;
        end else if (!wr) begin
            opQ.push_back('{1'b0, wa, 32'd0, d1});
            lat += phaseLen(d1);
            if (d1 >= int'(TO)) begin
                r.err = 1'b1;
                r.rdata = 32'd0;
            end else begin
                r.rdata = loadModel(refMem[idx], half, addr);
            end
        end else if (!half) begin
            opQ.push_back('{1'b1, wa, wdata, d1});
            lat += phaseLen(d1);
            if (d1 >= int'(TO)) r.err = 1'b1;
            else refMem[idx] = wdata;
        end else begin
            opQ.push_back('{1'b0, wa, 32'd0, d1});
            lat += phaseLen(d1);
            if (d1 >= int'(TO)) begin
                r.err = 1'b1;
            end else begin
                merged = mergeModel(refMem[idx], wdata, addr);
                opQ.push_back('{1'b1, wa, merged, d2});
                lat += phaseLen(d2);
                if (d2 >= int'(TO)) r.err = 1'b1;
                else refMem[idx] = merged;
            end
        end
        r.cycle = cycleCnt + lat;
        if (expectResp) begin
            respQ.push_back(r);
            lastRdata = r.rdata;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_half  = half;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_half  = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (rst_n && resp_valid) begin
            if (respQ.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = respQ.pop_front();
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", cycleCnt, e.cycle);
                chk("ready_in_resp", 32'(req_ready), 32'd0);
            end
        end
    end

    // Memory responder: checks each phase against the expected operation and acks it.
    initial begin : responder
        op_t op;
        int  k;
        int  idx;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !mem_en) begin
                mem_ack = 1'($urandom);   // stray acks with mem_en low must be ignored
                mem_rdata = $urandom;
            end else if (opQ.size() == 0) begin
                mem_ack = 1'b0;
                chk("unexpected_mem_access", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                op = opQ.pop_front();
                idx = int'(mem_addr % MemWords);
                chk("mem_we", 32'(mem_we), 32'(op.we));
                chk("mem_addr", 32'(mem_addr), 32'(op.addr));
                if (op.we) chk("mem_wdata", mem_wdata, op.wdata);
                k = 0;
                forever begin
                    if (k == op.delay && op.delay < int'(TO)) begin
                        mem_ack = 1'b1;
                        mem_rdata = simMem[idx];
                        if (mem_we) simMem[idx] = mem_wdata;
                        @(posedge clk); #1;
                        if (rst_n) chk("mem_en_low_after_ack", 32'(mem_en), 32'd0);
                        mem_ack = 1'($urandom);
                        mem_rdata = $urandom;
                        break;
                    end
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                    @(posedge clk); #1;
                    k++;
                    if (!rst_n) break;
                    if (k == int'(TO)) begin
                        chk("mem_en_drop_on_timeout", 32'(mem_en), 32'd0);
                        mem_ack = 1'($urandom);
                        break;
                    end
                    chk("mem_en_held", 32'(mem_en), 32'd1);
                    chk("mem_addr_held", 32'(mem_addr), 32'(op.addr));
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        logic wr, half;
        logic [31:0] addr;
        int d1, d2;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_half  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < MemWords; i++) setMem(i, $urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        setMem(4, 32'hDEAD_BEEF);
        doReq(1'b0, 1'b0, 32'h10, 32'd0, 1, 0, 1'b1);
        waitIdle();
        setMem(4, 32'h8001_7FFF);
        doReq(1'b0, 1'b1, 32'h12, 32'd0, 0, 0, 1'b1);
        doReq(1'b0, 1'b1, 32'h10, 32'd0, 0, 0, 1'b1);
        waitIdle();
        setMem(8, 32'h1111_2222);
        doReq(1'b1, 1'b1, 32'h22, 32'h0000_ABCD, 0, 0, 1'b1);
        doReq(1'b0, 1'b0, 32'h20, 32'd0, 0, 0, 1'b1);
        doReq(1'b0, 1'b0, 32'h6, 32'd0, 0, 0, 1'b1);
        doReq(1'b1, 1'b1, 32'h5, 32'h1234_5678, 0, 0, 1'b1);
        doReq(1'b0, 1'b0, 32'h10, 32'd0, TO, 0, 1'b1);
        doReq(1'b0, 1'b0, 32'h10, 32'd0, TO - 1, 0, 1'b1);
        doReq(1'b1, 1'b1, 32'h32, 32'h0000_5A5A, TO, 0, 1'b1);
        doReq(1'b1, 1'b1, 32'h30, 32'h0000_A5A5, 0, TO, 1'b1);
        doReq(1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, TO, 0, 1'b1);
        waitIdle();

        // Reset while the RMW write phase is waiting for its ack.
        doReq(1'b1, 1'b1, 32'h44, 32'h0000_7777, 0, TO, 1'b0);
        guard = 0;
        while (!(mem_en && mem_we) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) boundFail("rmw_write_phase");
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        lastRdata = 32'd0;
        @(posedge clk); #1;
        doReq(1'b1, 1'b0, 32'h44, 32'h0BAD_CAFE, 0, 0, 1'b1);
        doReq(1'b0, 1'b0, 32'h44, 32'd0, 0, 0, 1'b1);

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            wr   = 1'($urandom);
            half = 1'($urandom);
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) addr = addr + ($urandom << 8);
            if ($urandom_range(0, 4) != 0) addr = half ? addr - (addr % 2) : addr - (addr % 4);
            d1 = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            d2 = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            doReq(wr, half, addr, $urandom, d1, d2, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        waitIdle();

        for (int i = 0; i < MemWords; i++) chk("mem_contents", simMem[i], refMem[i]);
        chk("op_queue_empty", 32'(opQ.size()), 32'd0);
        chk("resp_queue_empty", 32'(respQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle control unit and external instruction/data memory.
- Takes one word or halfword load/store request at a time and drives a single-port memory with an ack-based wait-state handshake.
- Halfword stores are done as read-modify-write (RMW). Halfword loads are sign-extended.
- Returns a one-cycle response so the control FSM knows when it may leave its memory state.

Parameters:
- TIMEOUT, 15: maximum cycles mem_en may stay high without mem_ack before the access is aborted. Legal range 1..255.
- AW, 30: width of the word address sent to memory.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1=store, 0=load
- req_half  in  1  1=halfword (LoadHalf/SaveHalf), 0=word
- req_addr  in  32  byte address
- req_wdata  in  32  store data; for halfword stores only bits 15:0 are used
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid: misaligned access or timeout
- resp_rdata  out  32  load result; held until the next response
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  word address, equal to req_addr[31:2]
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  memory completes the current access this cycle

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Timeout counter=0.
- Reset asserted mid-access abandons the access immediately. No response is produced.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid=1.
  - Latch addr, half, write and wdata on accept. The requester may change its inputs after that.
- Alignment check at accept:
  - Word access needs addr[1:0]=0. Halfword access needs addr[0]=0.
  - Misaligned: go to RESP with err=1 and rdata=0. No memory cycle is issued.
- Routing at accept:
  - Word load or halfword load -> RD.
  - Word store -> WR.
  - Halfword store -> RMW_RD.
- mem_en, mem_we, mem_addr and mem_wdata are registered outputs. They go valid in the cycle after accept (or after the state change) and stay stable until mem_ack is sampled high.
- RD / RMW_RD: mem_en=1, mem_we=0.
- WR / RMW_WR: mem_en=1, mem_we=1.
- RD, on ack:
  - Word: rdata=mem_rdata.
  - Halfword: select half with addr[1] (0 -> bits 15:0, 1 -> bits 31:16; little-endian), then sign-extend to 32 bits.
  - Then -> RESP.
- RMW_RD, on ack:
  - Merged word: if addr[1]=0, {mem_rdata[31:16], wdata[15:0]}; else {wdata[15:0], mem_rdata[15:0]}.
  - Merged word goes to mem_wdata. Then -> RMW_WR.
  - mem_en drops for exactly one cycle between the two phases.
- WR / RMW_WR: on ack -> RESP. rdata is left unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_err as determined. Then -> IDLE.
  - req_ready=0, so a new request cannot be accepted in the same cycle.
- Timeout:
  - The counter clears on entry to each memory state and increments each cycle mem_en=1 and mem_ack=0.
  - When counter reaches TIMEOUT with no ack: drop mem_en, then -> RESP with err=1.
  - A load that times out returns rdata=0.
  - An RMW that times out in either phase performs no write, or only a partial one, and reports err.
- Ack in the same cycle the counter reaches TIMEOUT: the ack wins and the access completes normally.
- mem_ack while mem_en=0 is ignored.
- Latency from accept to resp_valid, with ack on the first cycle of mem_en:
  - Word/half load: 3 cycles.
  - Word store: 3 cycles.
  - Halfword store: 5 cycles.
  - Misaligned: 1 cycle.
  - Each cycle of ack delay adds one cycle.

Test Plan:
- Word load, addr=0x0000_0010, mem_rdata=0xDEADBEEF, ack 2 cycles after mem_en -> mem_addr=0x4; resp_valid 4 cycles after accept; resp_rdata=0xDEADBEEF; resp_err=0.
- Halfword load, addr=0x12, mem_rdata=0x8001_7FFF, immediate ack -> resp_rdata=0xFFFF_8001. Repeat with addr=0x10 -> resp_rdata=0x0000_7FFF.
- Halfword store, addr=0x22, wdata=0x0000_ABCD, memory word holds 0x1111_2222 -> read phase (we=0), one idle cycle, then write phase with mem_wdata=0xABCD_2222; resp_valid at cycle 5; resp_err=0.
- Misaligned word load addr=0x6 and misaligned half store addr=0x5 -> mem_en never asserts; resp_valid next cycle with resp_err=1.
- Timeout: TIMEOUT=4, word load, mem_ack held 0 -> mem_en high 4 cycles then low; resp_err=1; resp_rdata=0. Second case: ack arriving exactly on the 4th cycle -> normal completion with no error.
- Reset: drop rst_n during RMW_WR -> mem_en=0 and req_ready=1 immediately; no resp_valid. A new word store after reset release completes normally.
